// File: rtl/dwc_upconv_wchan_pack_ctrl.sv
// Upsizing W-channel packer sequencer: walks narrow beats into byte lanes of the wide
// word, decides when the wide word is flushed, and pops the hold register after the last wide beat.
module dwc_upconv_wchan_pack_ctrl #(
   parameter int unsigned DATA_WIDTH_IN  = 32,
   parameter int unsigned DATA_WIDTH_OUT = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       hold_reg_empty,
   input  logic [5:0] hold_addr,
   input  logic [2:0] hold_size,
   input  logic [7:0] hold_wlen,
   input  logic       hold_fixed,
   input  logic       hold_wrap,
   output logic       hold_get_next_data,
   input  logic       s_wvalid,
   input  logic       s_wlast,
   output logic       s_wready,
   output logic       acc_we,
   output logic [5:0] acc_lane,
   output logic       acc_clr,
   output logic       m_wvalid,
   output logic       m_wlast,
   input  logic       m_wready,
   output logic       busy,
   output logic       wlast_err
);

   localparam int unsigned IN_BYTES  = DATA_WIDTH_IN / 8;
   localparam int unsigned OUT_BYTES = DATA_WIDTH_OUT / 8;
   localparam logic [5:0]  LANE_MASK = 6'(OUT_BYTES - 1);
   localparam logic [5:0]  SZ_MASK   = 6'(2 * IN_BYTES - 1);

   typedef enum logic [1:0] {IDLE, PACK, FLUSH} state_e;

   state_e     state_q, state_d;
   logic [5:0] ptr_q, ptr_d;
   logic [7:0] cnt_q, cnt_d;
   logic       m_wvalid_q, m_wvalid_d;
   logic       m_wlast_q, m_wlast_d;
   logic       wlast_err_q, wlast_err_d;

   logic [5:0] sz, len_p1, wm, ptr_inc, ptr_nx;
   logic       cnt_zero, beat_flush, w_hs;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         cnt_q       <= '0;
         m_wvalid_q  <= 1'b0;
         m_wlast_q   <= 1'b0;
         wlast_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         m_wvalid_q  <= m_wvalid_d;
         m_wlast_q   <= m_wlast_d;
         wlast_err_q <= wlast_err_d;
      end
   end

   // 6-bit arithmetic throughout: a 64-byte step or wrap window folds to the full pointer range.
   always_comb begin
      sz         = (6'd1 << hold_size) & SZ_MASK;
      len_p1     = hold_wlen[5:0] + 6'd1;
      wm         = (len_p1 << hold_size) - 6'd1;
      ptr_inc    = ptr_q + sz;
      if (hold_fixed)
         ptr_nx = ptr_q;
      else if (hold_wrap)
         ptr_nx = (ptr_q & ~wm) | (ptr_inc & wm);
      else
         ptr_nx = ptr_inc;
      cnt_zero   = (cnt_q == 8'd0);
      beat_flush = cnt_zero | hold_fixed | ((ptr_nx & LANE_MASK) == 6'd0);
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      m_wvalid_d  = m_wvalid_q;
      m_wlast_d   = m_wlast_q;
      wlast_err_d = wlast_err_q;

      unique case (state_q)
         PACK:    s_wready = 1'b1;
         FLUSH:   s_wready = m_wready & ~m_wlast_q;
         default: s_wready = 1'b0;
      endcase
      acc_we             = s_wvalid & s_wready;
      w_hs               = (state_q == FLUSH) & m_wvalid_q & m_wready;
      acc_clr            = w_hs;
      hold_get_next_data = w_hs & m_wlast_q;

      if (state_q == IDLE) begin
         if (!hold_reg_empty) begin
            ptr_d   = hold_addr & ~(sz - 6'd1);
            cnt_d   = hold_wlen;
            state_d = PACK;
         end
      end else begin
         if (w_hs) begin
            m_wvalid_d = 1'b0;
            m_wlast_d  = 1'b0;
            state_d    = m_wlast_q ? IDLE : PACK;
         end
         // A beat taken alongside a non-last flush overrides the return to PACK.
         if (acc_we) begin
            ptr_d = ptr_nx;
            if (!cnt_zero)
               cnt_d = cnt_q - 8'd1;
            if (s_wlast != cnt_zero)
               wlast_err_d = 1'b1;
            if (beat_flush) begin
               m_wvalid_d = 1'b1;
               m_wlast_d  = cnt_zero;
               state_d    = FLUSH;
            end
         end
      end
   end

   assign acc_lane  = ptr_q & LANE_MASK;
   assign m_wvalid  = m_wvalid_q;
   assign m_wlast   = m_wlast_q;
   assign busy      = (state_q != IDLE);
   assign wlast_err = wlast_err_q;

endmodule

// File: tb/tb_dwc_upconv_wchan_pack_ctrl.sv
// Scoreboard bench for dwc_upconv_wchan_pack_ctrl (32-bit in, 64-bit out): directed bursts,
// expected lanes and wide-beat lasts are queued by the stimulus and checked by a monitor.
module tb_dwc_upconv_wchan_pack_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       hold_reg_empty = 1'b1;
   logic [5:0] hold_addr = '0;
   logic [2:0] hold_size = '0;
   logic [7:0] hold_wlen = '0;
   logic       hold_fixed = 1'b0;
   logic       hold_wrap = 1'b0;
   logic       hold_get_next_data;
   logic       s_wvalid = 1'b0;
   logic       s_wlast = 1'b0;
   logic       s_wready;
   logic       acc_we;
   logic [5:0] acc_lane;
   logic       acc_clr;
   logic       m_wvalid;
   logic       m_wlast;
   logic       m_wready = 1'b1;
   logic       busy;
   logic       wlast_err;

   int unsigned total_cnt = 0;
   int unsigned pass_cnt  = 0;
   int unsigned pop_cnt   = 0;
   int unsigned exp_pops  = 0;
   int unsigned exp_lane_q[$];
   int unsigned exp_wide_q[$];

   dwc_upconv_wchan_pack_ctrl #(
      .DATA_WIDTH_IN (32),
      .DATA_WIDTH_OUT(64)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .hold_reg_empty    (hold_reg_empty),
      .hold_addr         (hold_addr),
      .hold_size         (hold_size),
      .hold_wlen         (hold_wlen),
      .hold_fixed        (hold_fixed),
      .hold_wrap         (hold_wrap),
      .hold_get_next_data(hold_get_next_data),
      .s_wvalid          (s_wvalid),
      .s_wlast           (s_wlast),
      .s_wready          (s_wready),
      .acc_we            (acc_we),
      .acc_lane          (acc_lane),
      .acc_clr           (acc_clr),
      .m_wvalid          (m_wvalid),
      .m_wlast           (m_wlast),
      .m_wready          (m_wready),
      .busy              (busy),
      .wlast_err         (wlast_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   // Monitor: mid-cycle sampling of beat writes, wide handshakes and pops.
   initial begin
      forever begin
         @(negedge clk);
         if (hold_get_next_data) pop_cnt++;
         if (acc_we) begin
            if (exp_lane_q.size() == 0) chk("lane_unexpected", 1, 0);
            else chk("acc_lane", 32'(acc_lane), exp_lane_q.pop_front());
         end
         if (m_wvalid && m_wready) begin
            chk("acc_clr", 32'(acc_clr), 1);
            if (exp_wide_q.size() == 0) chk("wide_unexpected", 1, 0);
            else chk("m_wlast", 32'(m_wlast), exp_wide_q.pop_front());
         end else if (acc_clr) begin
            chk("acc_clr_stray", 1, 0);
         end
      end
   end

   task automatic start_burst(input logic [5:0] a, input logic [2:0] sz, input logic [7:0] len,
                              input logic fx, input logic wr);
      int n = 0;
      hold_addr = a; hold_size = sz; hold_wlen = len; hold_fixed = fx; hold_wrap = wr;
      hold_reg_empty = 1'b0;
      do begin
         @(posedge clk); #1; n++;
      end while (!busy && n < 10);
      chk("start_busy", 32'(busy), 1);
      hold_reg_empty = 1'b1;
   endtask

   task automatic send_beat(input int unsigned lane, input logic last);
      int n = 0;
      exp_lane_q.push_back(lane);
      s_wvalid = 1'b1;
      s_wlast  = last;
      do begin
         @(negedge clk); n++;
      end while (!s_wready && n < 50);
      if (!s_wready) chk("beat_timeout", 0, 1);
      @(posedge clk); #1;
      s_wvalid = 1'b0;
      s_wlast  = 1'b0;
   endtask

   task automatic finish_burst(input string nm, input int unsigned err);
      int n = 0;
      while (busy && n < 100) begin
         @(posedge clk); #1; n++;
      end
      repeat (2) @(posedge clk);
      #1;
      exp_pops++;
      chk({nm, "_idle"}, 32'(busy), 0);
      chk({nm, "_pops"}, pop_cnt, exp_pops);
      chk({nm, "_lanes_left"}, exp_lane_q.size(), 0);
      chk({nm, "_wide_left"}, exp_wide_q.size(), 0);
      chk({nm, "_wlast_err"}, 32'(wlast_err), err);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_m_wvalid", 32'(m_wvalid), 0);
      chk("rst_s_wready", 32'(s_wready), 0);
      chk("rst_lane", 32'(acc_lane), 0);
      chk("rst_err", 32'(wlast_err), 0);
      rst = 1'b1;
      @(posedge clk); #1;

      // 1: INCR addr 0, 4 beats
      exp_wide_q.push_back(0); exp_wide_q.push_back(1);
      start_burst(6'd0, 3'd2, 8'd3, 1'b0, 1'b0);
      send_beat(0, 0); send_beat(4, 0); send_beat(0, 0); send_beat(4, 1);
      finish_burst("incr0", 0);

      // 2: INCR addr 4, flush after the first beat
      exp_wide_q.push_back(0); exp_wide_q.push_back(1);
      start_burst(6'd4, 3'd2, 8'd2, 1'b0, 1'b0);
      send_beat(4, 0); send_beat(0, 0); send_beat(4, 1);
      finish_burst("incr4", 0);

      // 3: FIXED, one narrow beat per wide beat
      exp_wide_q.push_back(0); exp_wide_q.push_back(1);
      start_burst(6'd4, 3'd2, 8'd1, 1'b1, 1'b0);
      send_beat(4, 0); send_beat(4, 1);
      finish_burst("fixed", 0);

      // 4: WRAP addr 8, window 16 bytes
      exp_wide_q.push_back(0); exp_wide_q.push_back(1);
      start_burst(6'd8, 3'd2, 8'd3, 1'b0, 1'b1);
      send_beat(0, 0); send_beat(4, 0); send_beat(0, 0); send_beat(4, 1);
      finish_burst("wrap", 0);

      // single unaligned beat: address aligned down to the beat size
      exp_wide_q.push_back(1);
      start_burst(6'd6, 3'd2, 8'd0, 1'b0, 1'b0);
      send_beat(4, 1);
      finish_burst("single", 0);

      // 5: case 1 with a 3-cycle stall at the first flush
      exp_wide_q.push_back(0); exp_wide_q.push_back(1);
      m_wready = 1'b0;
      start_burst(6'd0, 3'd2, 8'd3, 1'b0, 1'b0);
      fork
         begin
            send_beat(0, 0); send_beat(4, 0); send_beat(0, 0); send_beat(4, 1);
         end
         begin
            int n = 0;
            do begin
               @(negedge clk); n++;
            end while (!m_wvalid && n < 50);
            for (int i = 0; i < 3; i++) begin
               if (i > 0) @(negedge clk);
               chk("stall_s_wready", 32'(s_wready), 0);
               chk("stall_acc_we", 32'(acc_we), 0);
               chk("stall_m_wvalid", 32'(m_wvalid), 1);
               chk("stall_lane", 32'(acc_lane), 0);
            end
            @(posedge clk); #1;
            m_wready = 1'b1;
         end
      join
      finish_burst("stall", 0);

      // 6: early s_wlast on beat 1; counter still governs the burst
      exp_wide_q.push_back(0); exp_wide_q.push_back(1);
      start_burst(6'd0, 3'd2, 8'd3, 1'b0, 1'b0);
      send_beat(0, 0);
      chk("err_before", 32'(wlast_err), 0);
      send_beat(4, 1);
      chk("err_after", 32'(wlast_err), 1);
      send_beat(0, 0); send_beat(4, 1);
      finish_burst("wlast", 1);

      // reset in the middle of a burst
      start_burst(6'd0, 3'd2, 8'd3, 1'b0, 1'b0);
      send_beat(0, 0);
      rst = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_m_wvalid", 32'(m_wvalid), 0);
      chk("mid_rst_s_wready", 32'(s_wready), 0);
      chk("mid_rst_lane", 32'(acc_lane), 0);
      chk("mid_rst_err", 32'(wlast_err), 0);
      chk("mid_rst_pop", 32'(hold_get_next_data), 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("post_rst_busy", 32'(busy), 0);
      chk("post_rst_pops", pop_cnt, exp_pops);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
